// File: rtl/fft_power_averager_if.sv
// Stream bundle between the FFT core, the power averager and the spectrum readout.
// The averager takes the slave side; the FFT source and readout sink take the master side.
interface fft_power_averager_if #(
   parameter int FFT_BITS = 14,
   parameter int FFT_PTS  = 1024
);
   localparam int BIN_W = $clog2(FFT_PTS);

   logic signed [FFT_BITS-1:0] in_real;
   logic signed [FFT_BITS-1:0] in_imag;
   logic                       in_valid;
   logic                       in_sop;
   logic                       in_eop;

   logic [2*FFT_BITS:0]        out_power;
   logic [BIN_W-1:0]           out_bin;
   logic                       out_valid;
   logic                       out_ready;
   logic                       out_sop;
   logic                       out_eop;

   logic                       frame_err;
   logic [7:0]                 drop_cnt;

   modport master (
      output in_real, in_imag, in_valid, in_sop, in_eop, out_ready,
      input  out_power, out_bin, out_valid, out_sop, out_eop, frame_err, drop_cnt
   );

   modport slave (
      input  in_real, in_imag, in_valid, in_sop, in_eop, out_ready,
      output out_power, out_bin, out_valid, out_sop, out_eop, frame_err, drop_cnt
   );
endinterface

// File: rtl/fft_power_averager.sv
// Per-bin power (re^2+im^2) averaged over 2^AVG_LOG2 good FFT frames in a bin buffer,
// then streamed out bin by bin under a valid/ready handshake.
module fft_power_averager #(
   parameter int FFT_BITS = 14,
   parameter int FFT_PTS  = 1024,
   parameter int AVG_LOG2 = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   fft_power_averager_if.slave  bus
);
   localparam int BIN_W = $clog2(FFT_PTS);
   localparam int P_W   = 2*FFT_BITS + 1;
   localparam int ACC_W = P_W + AVG_LOG2;
   localparam int FC_W  = AVG_LOG2 + 1;

   localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(FFT_PTS - 1);
   localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'((1 << AVG_LOG2) - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state;
   logic [BIN_W-1:0] bin_cnt;
   logic [FC_W-1:0]  frame_cnt;
   logic             in_frame;
   logic             frame_err_q;
   logic [7:0]       drop_cnt_q;

   // Accumulate pipeline: stage 1 holds the registered sample, stage 2 the power
   logic                       s1_wr, s1_first;
   logic [BIN_W-1:0]           s1_bin;
   logic signed [FFT_BITS-1:0] s1_re, s1_im;
   logic                       s2_wr, s2_first;
   logic [BIN_W-1:0]           s2_bin;
   logic [P_W-1:0]             s2_p;

   logic [ACC_W-1:0] mem [FFT_PTS];
   logic [ACC_W-1:0] rd_data;
   logic [ACC_W-1:0] wr_data;
   logic             rd_en;
   logic [BIN_W-1:0] rd_addr;

   logic [BIN_W:0]   drain_cnt;
   logic             out_valid_q, out_sop_q, out_eop_q;
   logic [BIN_W-1:0] out_bin_q;

   logic take, restart, bad, done, first;
   logic drain_load, xfer;

   logic signed [2*FFT_BITS-1:0] re_sq, im_sq;
   logic [P_W-1:0]               p_next;

   assign re_sq  = s1_re * s1_re;
   assign im_sq  = s1_im * s1_im;
   assign p_next = {1'b0, re_sq} + {1'b0, im_sq};

   // Sample classification: take = write into the buffer, restart = sample opens a frame.
   // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      take    = 1'b0;
      restart = 1'b0;
      bad     = 1'b0;
      done    = 1'b0;
      if (state != S_DRAIN && bus.in_valid) begin
         if (bus.in_sop) begin
            if (state == S_ACCUM && in_frame) bad = 1'b1;
            if (bus.in_eop) begin
               bad = 1'b1;
            end else begin
               take    = 1'b1;
               restart = 1'b1;
            end
         end else if (state == S_ACCUM && in_frame) begin
            if (bus.in_eop != (bin_cnt == LAST_BIN)) begin
               bad = 1'b1;
            end else begin
               take = 1'b1;
               done = bus.in_eop;
            end
         end
      end
   end

   // A sop that aborts a frame always begins a fresh average
   assign first = bad || (frame_cnt == '0);

   assign xfer       = out_valid_q && bus.out_ready;
   assign drain_load = (state == S_DRAIN) && !s1_wr && !s2_wr && !drain_cnt[BIN_W] &&
                       (!out_valid_q || bus.out_ready);

   always_ff @(posedge clk) begin
      if (take) begin
         s1_re    <= bus.in_real;
         s1_im    <= bus.in_imag;
         s1_bin   <= restart ? '0 : bin_cnt;
         s1_first <= first;
      end
      s2_bin   <= s1_bin;
      s2_first <= s1_first;
      s2_p     <= p_next;
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         bin_cnt     <= '0;
         frame_cnt   <= '0;
         in_frame    <= 1'b0;
         frame_err_q <= 1'b0;
         drop_cnt_q  <= '0;
         s1_wr       <= 1'b0;
         s2_wr       <= 1'b0;
         drain_cnt   <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_bin_q   <= '0;
      end else begin
         s1_wr <= take;
         s2_wr <= s1_wr;
         if (bad) frame_err_q <= 1'b1;

         case (state)
            S_IDLE: begin
               if (restart) begin
                  state     <= S_ACCUM;
                  in_frame  <= 1'b1;
                  bin_cnt   <= BIN_W'(1);
                  frame_cnt <= '0;
               end
            end
            S_ACCUM: begin
               if (restart) begin
                  in_frame <= 1'b1;
                  bin_cnt  <= BIN_W'(1);
                  if (bad) frame_cnt <= '0;
               end else if (bad) begin
                  state     <= S_IDLE;
                  in_frame  <= 1'b0;
                  bin_cnt   <= '0;
                  frame_cnt <= '0;
               end else if (done) begin
                  in_frame <= 1'b0;
                  bin_cnt  <= '0;
                  if (frame_cnt == LAST_FRAME) begin
                     state     <= S_DRAIN;
                     frame_cnt <= '0;
                     drain_cnt <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end else if (take) begin
                  bin_cnt <= bin_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (bus.in_valid && bus.in_sop && drop_cnt_q != 8'hFF)
                  drop_cnt_q <= drop_cnt_q + 1'b1;
               if (xfer && out_eop_q) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // The output register only reloads once the current bin has been accepted
         if (drain_load) begin
            out_valid_q <= 1'b1;
            out_bin_q   <= drain_cnt[BIN_W-1:0];
            out_sop_q   <= (drain_cnt[BIN_W-1:0] == '0);
            out_eop_q   <= (drain_cnt[BIN_W-1:0] == LAST_BIN);
            drain_cnt   <= drain_cnt + 1'b1;
         end else if (xfer) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
         end
      end
   end

   // One read port shared by the read-modify-write path and the drain
   assign rd_en   = drain_load || s1_wr;
   assign rd_addr = drain_load ? drain_cnt[BIN_W-1:0] : s1_bin;
   assign wr_data = (s2_first ? '0 : rd_data) + ACC_W'(s2_p);

   // NOTE: the bin buffer has no reset; frame 0 of every set overwrites each bin before it is read.
   always_ff @(posedge clk) begin
      if (s2_wr) mem[s2_bin] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   assign bus.out_power = out_valid_q ? P_W'(rd_data >> AVG_LOG2) : '0;
   assign bus.out_bin   = out_bin_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sop   = out_sop_q;
   assign bus.out_eop   = out_eop_q;
   assign bus.frame_err = frame_err_q;
   assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_fft_power_averager.sv
// Randomised bench for fft_power_averager: frame-level reference model feeds a scoreboard
// queue, an independent monitor checks every transferred bin and stall stability.
module tb_fft_power_averager;
   localparam int FB   = 14;
   localparam int NP   = 16;
   localparam int AL   = 2;
   localparam int NAVG = 1 << AL;

   typedef struct {
      longint power;
      int     bin;
      bit     sop;
      bit     eop;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   fft_power_averager_if #(.FFT_BITS(FB), .FFT_PTS(NP)) bus ();

   fft_power_averager #(.FFT_BITS(FB), .FFT_PTS(NP), .AVG_LOG2(AL)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int     n_checks = 0;
   int     n_pass   = 0;
   exp_t   exp_q[$];
   longint sum[NP];
   int     nfr      = 0;
   int     exp_err  = 0;
   int     exp_drop = 0;
   int     fr_re[NP];
   int     fr_im[NP];
   int     rdy_mode = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: a set is 2^AL good frames; its output is floor(mean power) per bin
   task automatic model_clear();
      for (int b = 0; b < NP; b++) sum[b] = 0;
      nfr = 0;
   endtask

   task automatic model_good();
      exp_t e;
      for (int b = 0; b < NP; b++)
         sum[b] += longint'(fr_re[b]) * fr_re[b] + longint'(fr_im[b]) * fr_im[b];
      nfr++;
      if (nfr == NAVG) begin
         for (int b = 0; b < NP; b++) begin
            e.power = sum[b] / NAVG;
            e.bin   = b;
            e.sop   = (b == 0);
            e.eop   = (b == NP-1);
            exp_q.push_back(e);
         end
         model_clear();
      end
   endtask

   task automatic model_bad();
      model_clear();
      exp_err = 1;
   endtask

   task automatic fill(input int kind, input int a, input int b);
      for (int i = 0; i < NP; i++) begin
         case (kind)
            0: begin fr_re[i] = a; fr_im[i] = b; end
            1: begin fr_re[i] = i; fr_im[i] = 0; end
            default: begin
               fr_re[i] = int'($urandom_range(0, 16383)) - 8192;
               fr_im[i] = int'($urandom_range(0, 16383)) - 8192;
            end
         endcase
      end
   endtask

   task automatic drive_sample(input int re, input int im, input bit sop, input bit eop);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_real  = FB'(re);
      bus.in_imag  = FB'(im);
      bus.in_sop   = sop;
      bus.in_eop   = eop;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         bus.in_sop   = 1'b0;
         bus.in_eop   = 1'b0;
      end
   endtask

   // eop_pos < 0 sends no eop at all
   task automatic send_frame(input int n, input int eop_pos);
      for (int i = 0; i < n; i++)
         drive_sample(fr_re[i], fr_im[i], i == 0, i == eop_pos);
   endtask

   task automatic run_set(input int kind, input int a, input int b, input int gap);
      for (int f = 0; f < NAVG; f++) begin
         fill(kind, a, b);
         send_frame(NP, NP-1);
         model_good();
         if (f < NAVG-1 && gap > 0) idle(gap);
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      idle(1);
      while ((exp_q.size() != 0 || bus.out_valid) && t < 2000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 2000) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d bins still outstanding, expected 0", exp_q.size());
      end
      idle(2);
      check("frame_err", bus.frame_err, exp_err);
      check("drop_cnt", bus.drop_cnt, exp_drop);
   endtask

   // Ready generator: 0 = always ready, 1 = repeating 1-0-0-1, 2 = random
   initial begin
      int rcnt = 0;
      logic [3:0] pat = 4'b1001;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         rcnt++;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = pat[rcnt % 4];
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on every transfer and checks held data while stalled
   initial begin
      exp_t e;
      bit          stalled = 0;
      logic [2*FB:0] h_power;
      logic [3:0]    h_bin;
      logic          h_sop, h_eop;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            stalled = 0;
         end else begin
            if (stalled) begin
               check("hold_valid", bus.out_valid, 1);
               check("hold_power", bus.out_power, h_power);
               check("hold_bin", bus.out_bin, h_bin);
               check("hold_sop", bus.out_sop, h_sop);
               check("hold_eop", bus.out_eop, h_eop);
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_output: bin %0d power %0d, expected no output",
                           bus.out_bin, bus.out_power);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("bin%0d_power", e.bin), bus.out_power, e.power);
                  check($sformatf("bin%0d_index", e.bin), bus.out_bin, e.bin);
                  check($sformatf("bin%0d_sop", e.bin), bus.out_sop, e.sop);
                  check($sformatf("bin%0d_eop", e.bin), bus.out_eop, e.eop);
               end
            end
            stalled = bus.out_valid && !bus.out_ready;
            h_power = bus.out_power;
            h_bin   = bus.out_bin;
            h_sop   = bus.out_sop;
            h_eop   = bus.out_eop;
         end
      end
   end

   initial begin
      int t;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      bus.in_real  = '0;
      bus.in_imag  = '0;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_sop", bus.out_sop, 0);
      check("rst_out_eop", bus.out_eop, 0);
      check("rst_out_power", bus.out_power, 0);
      check("rst_out_bin", bus.out_bin, 0);
      check("rst_frame_err", bus.frame_err, 0);
      check("rst_drop_cnt", bus.drop_cnt, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle(2);

      // Back-to-back frames of 3+4j, plus first-output latency after the final eop
      run_set(0, 3, 4, 0);
      idle(1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("latency_before", bus.out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      check("latency_first", bus.out_valid, 1);
      wait_drain();

      // Full-scale negative corner, then ramp re=k
      run_set(0, -8192, -8192, 1);
      wait_drain();
      run_set(1, 0, 0, 0);
      wait_drain();

      // Averaging floor: P = 1,2,2,2
      fill(0, 1, 0); send_frame(NP, NP-1); model_good();
      for (int f = 0; f < 3; f++) begin
         fill(0, 1, 1); send_frame(NP, NP-1); model_good();
      end
      wait_drain();

      // Short frame inside a set discards it
      fill(0, 7, -2); send_frame(NP, NP-1); model_good();
      fill(0, 5, 5);  send_frame(10, 9);    model_bad();
      idle(2);
      run_set(2, 0, 0, 0);
      wait_drain();

      // Stalled drain with a frame arriving mid-drain
      rdy_mode = 1;
      run_set(0, 100, -50, 0);
      idle(4);
      fill(2, 0, 0);
      send_frame(NP, NP-1);
      exp_drop++;
      wait_drain();
      rdy_mode = 0;

      // Reset pulse at drain bin 5
      run_set(2, 0, 0, 0);
      idle(1);
      t = 0;
      while (!(bus.out_valid && bus.out_bin == 4'd5) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         n_checks++;
         $display("FAIL reset_wait: bin 5 never presented, expected it within 500 cycles");
      end
      reset_n = 1'b0;
      #1;
      check("rst_async_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      check("rst_edge_valid", bus.out_valid, 0);
      exp_q.delete();
      model_clear();
      exp_err  = 0;
      exp_drop = 0;
      @(negedge clk);
      reset_n = 1'b1;
      check("rst_clear_err", bus.frame_err, exp_err);
      check("rst_clear_drop", bus.drop_cnt, exp_drop);
      run_set(0, 1, 1, 0);
      wait_drain();

      // Random sets with random backpressure and occasional malformed frames
      rdy_mode = 2;
      for (int s = 0; s < 4; s++) begin
         if ($urandom_range(0, 1) == 1) begin
            int k = int'($urandom_range(0, 2));
            int kind = int'($urandom_range(0, 2));
            for (int f = 0; f < k; f++) begin
               fill(2, 0, 0); send_frame(NP, NP-1); model_good();
            end
            fill(2, 0, 0);
            case (kind)
               0: begin
                  t = int'($urandom_range(2, 14));
                  send_frame(t, t-1);
                  idle(1);
               end
               1: begin
                  send_frame(NP, -1);
                  idle(1);
               end
               default: send_frame(int'($urandom_range(3, 14)), -1);
            endcase
            model_bad();
         end
         run_set(2, 0, 0, int'($urandom_range(0, 2)));
         wait_drain();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fft_power_averager.md
# fft_power_averager

Downstream stage of the streaming FFT core. It consumes the core's complex output frames (real, imag, valid, sop, eop) and forms per-bin power re²+im². It accumulates 2^AVG_LOG2 consecutive good frames in an on-chip bin buffer, then streams the averaged power spectrum out with a valid/ready handshake. Its output feeds the spectrum display/readout logic.

## Interface
- FFT_BITS, 14, width of signed FFT output real/imag samples
- FFT_PTS, 1024, bins per frame (power of two, ≥4)
- AVG_LOG2, 2, log2 of frames averaged (0..4)
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_real  in  FFT_BITS  signed real part from FFT
- in_imag  in  FFT_BITS  signed imaginary part from FFT
- in_valid  in  1  sample qualifier; no backpressure toward FFT
- in_sop  in  1  first bin of frame (valid only with in_valid)
- in_eop  in  1  last bin of frame (valid only with in_valid)
- out_power  out  2*FFT_BITS+1  averaged power, unsigned
- out_bin  out  log2(FFT_PTS)  bin index of out_power
- out_valid  out  1  output qualifier
- out_ready  in  1  downstream accept
- out_sop  out  1  with bin 0
- out_eop  out  1  with bin FFT_PTS-1
- frame_err  out  1  sticky: malformed frame seen
- drop_cnt  out  8  saturating count of frames dropped while draining

## Operation
- Power path: P = re²+im², exact, 2*FFT_BITS+1 bits (no truncation). Accumulator width 2*FFT_BITS+1+AVG_LOG2. Output = acc >> AVG_LOG2 (floor).
- Bin buffer: FFT_PTS × accumulator width, single-port-read/single-port-write synchronous RAM.
- States:
  - IDLE: wait for in_valid&in_sop → ACCUM, bin counter = 0, frame counter = 0.
  - ACCUM: each valid sample writes buffer[bin]. Write is P for frame 0 of the average, buffer[bin]+P otherwise. bin increments.
    - Valid sample with in_eop at bin==FFT_PTS-1 completes the frame. frame counter increments.
    - When frame counter reaches 2^AVG_LOG2 → DRAIN. Otherwise wait for next sop.
  - DRAIN: read bins 0..FFT_PTS-1 in order and present them on out_*. After the handshake of bin FFT_PTS-1 → IDLE.
- Malformed frame (any of the following): in_eop before bin FFT_PTS-1; no eop at bin FFT_PTS-1; in_sop mid-frame.
  - Set frame_err.
  - Discard the current averaging set: frame counter = 0.
  - If the offending sample carried in_sop, it starts a new frame 0. Otherwise go to IDLE.
- Valid samples outside a frame (IDLE without sop, between frames in ACCUM) are ignored.
- In DRAIN, every in_sop seen increments drop_cnt (saturates at 255). Those frames are ignored.
- frame_err and drop_cnt clear only on reset.

## Timing
- Reset values: out_valid=0, out_sop=0, out_eop=0, out_power=0, out_bin=0, frame_err=0, drop_cnt=0, state IDLE.
- Accumulate pipeline: input register (1) → multiply/add register (1) → RAM write. A sample at cycle t is written at t+2.
  - Read-modify-write reads at t+1. Same-bin back-to-back hazard cannot occur (FFT_PTS ≥ 4).
  - A frame of FFT_PTS samples can be followed immediately by the next sop without gaps.
- DRAIN entry: the final write of the last frame completes before the first read. out_valid first rises 3 cycles after the accepting eop sample.
- Handshake: transfer when out_valid&out_ready.
  - While out_valid=1 and out_ready=0, out_power/out_bin/out_sop/out_eop hold stable.
  - With out_ready held high, one bin per cycle; the full spectrum takes FFT_PTS cycles.
  - out_valid must not drop before its transfer.
- Reset asserted mid-ACCUM or mid-DRAIN: outputs go to reset values immediately. Buffer contents are don't-care; the next set starts at frame 0 and overwrites.

## Test plan
- FFT_PTS=16, AVG_LOG2=2; 4 back-to-back frames, every sample re=3, im=4 → 16 outputs, all out_power=25, out_bin 0..15, sop on bin 0, eop on bin 15.
- Frames with re=−8192, im=−8192 (×4) → every out_power=134217728, no overflow. Frames with re=k (bin index), im=0 → out_power=k².
- Averaging floor: frame values P=1,2,2,2 for a bin → out_power=1 (7>>2).
- Short frame (eop at bin 9) inside set, then 4 good frames → frame_err=1; output equals average of the 4 good frames only.
- out_ready toggling 1-0-0-1 pattern during drain; sop of a new input frame during drain → no lost/duplicated bins, data stable while stalled, drop_cnt=1.
- Assert reset_n low for 1 cycle at drain bin 5 → out_valid=0 next edge; subsequent 4 frames of re=1, im=1 → all outputs 2.
